// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the control unit and the data RAM: alignment check,
// MFA/MOC handshake (two word beats for doubleword), and sign/zero extension of load data.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TW             = 5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        RW,
    input  logic [1:0]  dataSize,
    input  logic        SignedLd,
    input  logic [31:0] Addr,
    input  logic [63:0] WrData,
    input  logic        MemMOC,
    input  logic [31:0] MemDataIn,
    output logic        MemMFA,
    output logic        MemRW,
    output logic [1:0]  MemSize,
    output logic [31:0] MemAddr,
    output logic [31:0] MemDataOut,
    output logic [63:0] RdData,
    output logic        Done,
    output logic        Busy,
    output logic [1:0]  ErrCode,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic        rw_q, sgn_q, beat;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [TW-1:0] tcnt;

    logic        misaligned, timeout_hit, in_req, last_beat;
    logic [31:0] beat_wdata, ld_ext;

    always_comb begin
        misaligned = 1'b0;
        case (dataSize)
            2'b01:   misaligned = Addr[0];
            2'b10:   misaligned = |Addr[1:0];
            2'b11:   misaligned = |Addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign in_req      = (state == S_REQ);
    assign last_beat   = (size_q != 2'b11) || beat;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (Start) state_nx = misaligned ? S_ERR : S_REQ;
            S_REQ: begin
                if (MemMOC)           state_nx = last_beat ? S_DONE : S_GAP;
                else if (timeout_hit) state_nx = S_ERR;
            end
            S_GAP:   state_nx = S_REQ;
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Extension is chosen by the latched size; word and doubleword beats pass through.
    always_comb begin
        ld_ext = MemDataIn;
        case (size_q)
            2'b00:   ld_ext = {{24{sgn_q & MemDataIn[7]}}, MemDataIn[7:0]};
            2'b01:   ld_ext = {{16{sgn_q & MemDataIn[15]}}, MemDataIn[15:0]};
            default: ld_ext = MemDataIn;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rw_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 64'd0;
            beat    <= 1'b0;
            tcnt    <= '0;
            RdData  <= 64'd0;
            ErrCode <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (Start) begin
                    rw_q    <= RW;
                    sgn_q   <= SignedLd;
                    size_q  <= dataSize;
                    addr_q  <= Addr;
                    wdata_q <= WrData;
                    beat    <= 1'b0;
                    tcnt    <= '0;
                    RdData  <= 64'd0;
                    ErrCode <= misaligned ? 2'b01 : 2'b00;
                end
                S_REQ: begin
                    if (MemMOC) begin
                        if (rw_q) begin
                            if (beat) RdData[63:32] <= ld_ext;
                            else      RdData[31:0]  <= ld_ext;
                        end
                        // Counter is cleared here so the second beat starts a fresh timeout.
                        if (!last_beat) begin
                            beat <= 1'b1;
                            tcnt <= '0;
                        end
                    end else if (timeout_hit) begin
                        ErrCode <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign beat_wdata = beat ? wdata_q[63:32] : wdata_q[31:0];

    always_comb begin
        MemDataOut = 32'd0;
        if (in_req) begin
            case (size_q)
                2'b00:   MemDataOut = {24'd0, beat_wdata[7:0]};
                2'b01:   MemDataOut = {16'd0, beat_wdata[15:0]};
                default: MemDataOut = beat_wdata;
            endcase
        end
    end

    assign MemMFA    = in_req;
    assign MemRW     = in_req & rw_q;
    assign MemSize   = !in_req ? 2'b00 : ((size_q == 2'b11) ? 2'b10 : size_q);
    assign MemAddr   = in_req ? (addr_q + {29'd0, beat, 2'b00}) : 32'd0;
    assign Done      = (state == S_DONE) || (state == S_ERR);
    assign Busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single accesses run against a small
// RAM responder, plus hand sequences for start-while-busy and reset during a GAP.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        RW;
    logic [1:0]  dataSize;
    logic        SignedLd;
    logic [31:0] Addr;
    logic [63:0] WrData;
    logic        MemMOC;
    logic [31:0] MemDataIn;
    logic        MemMFA;
    logic        MemRW;
    logic [1:0]  MemSize;
    logic [31:0] MemAddr;
    logic [31:0] MemDataOut;
    logic [63:0] RdData;
    logic        Done;
    logic        Busy;
    logic [1:0]  ErrCode;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .RW(RW), .dataSize(dataSize),
        .SignedLd(SignedLd), .Addr(Addr), .WrData(WrData), .MemMOC(MemMOC),
        .MemDataIn(MemDataIn), .MemMFA(MemMFA), .MemRW(MemRW), .MemSize(MemSize),
        .MemAddr(MemAddr), .MemDataOut(MemDataOut), .RdData(RdData), .Done(Done),
        .Busy(Busy), .ErrCode(ErrCode), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        rw;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [31:0] d0, d1;
        int          dly0, dly1;
        int          exp_beats;
        logic [31:0] ea0, eo0, ea1, eo1;
        logic [1:0]  emsize;
        logic [63:0] exp_rd;
        logic [1:0]  exp_err;
        int          exp_mfa;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [63:0] wd);
        @(negedge Clk);
        Start = 1'b1; RW = rw; dataSize = sz; SignedLd = sgn; Addr = a; WrData = wd;
    endtask

    // Issues one access and plays the RAM side: MemMOC rises after dly REQ cycles of a
    // beat and is held until MemMFA drops.
    task automatic run_vec(input vec_t v);
        int  beats = 0, cyc = 0, mfa_n = 0, gap = 0, lat = 0;
        logic prev = 1'b0, busy_ok = 1'b1, seen = 1'b0;
        logic [63:0] rd_at_done = '0;
        logic [1:0]  err_at_done = '0;
        issue(v.rw, v.sz, v.sgn, v.addr, v.wdata);
        for (int n = 1; n <= 40; n++) begin
            if (!seen) begin
                @(negedge Clk);
                Start = 1'b0;
                if (MemMFA) begin
                    if (!prev) begin
                        beats++;
                        cyc = 0;
                        chk({v.name, "_addr"}, {32'd0, MemAddr}, {32'd0, (beats == 1) ? v.ea0 : v.ea1});
                        chk({v.name, "_dout"}, {32'd0, MemDataOut}, {32'd0, (beats == 1) ? v.eo0 : v.eo1});
                        chk({v.name, "_msize"}, {62'd0, MemSize}, {62'd0, v.emsize});
                        chk({v.name, "_mrw"}, {63'd0, MemRW}, {63'd0, v.rw});
                    end
                    if (cyc >= ((beats == 1) ? v.dly0 : v.dly1)) begin
                        MemMOC    = 1'b1;
                        MemDataIn = (beats == 1) ? v.d0 : v.d1;
                    end
                    cyc++;
                    mfa_n++;
                end else begin
                    MemMOC    = 1'b0;
                    MemDataIn = 32'd0;
                    if (!Done && beats == 1) gap++;
                end
                prev = MemMFA;
                if (!Busy) busy_ok = 1'b0;
                if (Done) begin
                    seen        = 1'b1;
                    lat         = n;
                    rd_at_done  = RdData;
                    err_at_done = ErrCode;
                end
            end
        end
        chk({v.name, "_done_seen"}, {63'd0, seen}, 64'd1);
        chk({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, "_mfa_cycles"}, 64'(mfa_n), 64'(v.exp_mfa));
        chk({v.name, "_beats"}, 64'(beats), 64'(v.exp_beats));
        chk({v.name, "_gap"}, 64'(gap), (v.exp_beats == 2) ? 64'd1 : 64'd0);
        chk({v.name, "_busy"}, {63'd0, busy_ok}, 64'd1);
        chk({v.name, "_rd"}, rd_at_done, v.exp_rd);
        chk({v.name, "_err"}, {62'd0, err_at_done}, {62'd0, v.exp_err});
        @(negedge Clk);
        chk({v.name, "_done_pulse"}, {62'd0, Done, Busy}, 64'd0);
        chk({v.name, "_rd_hold"}, RdData, v.exp_rd);
        chk({v.name, "_err_hold"}, {62'd0, ErrCode}, {62'd0, v.exp_err});
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {59'd0, MemMFA, MemRW, Done, Busy, 1'b0}, 64'd0);
        chk({nm, "_msize_err"}, {60'd0, MemSize, ErrCode}, 64'd0);
        chk({nm, "_maddr_dout"}, {MemAddr, MemDataOut}, 64'd0);
        chk({nm, "_rd"}, RdData, 64'd0);
    endtask

    initial begin
        //          name      rw   sz    sgn  addr          wdata                      d0            d1            dly0 dly1 beats ea0           eo0           ea1           eo1           msz   exp_rd                     err   mfa lat
        vecs[0]  = '{"sbyte",  1'b1, 2'b00, 1'b1, 32'h10,  64'h0,                     32'h00000085, 32'h0,        1,  0,  1, 32'h10,  32'h0,        32'h0,  32'h0,        2'b00, 64'h00000000_FFFFFF85, 2'b00, 2,  3};
        vecs[1]  = '{"uhalf",  1'b1, 2'b01, 1'b0, 32'h22,  64'h0,                     32'h00008001, 32'h0,        0,  0,  1, 32'h22,  32'h0,        32'h0,  32'h0,        2'b01, 64'h00000000_00008001, 2'b00, 1,  2};
        vecs[2]  = '{"shalf",  1'b1, 2'b01, 1'b1, 32'h22,  64'h0,                     32'h00008001, 32'h0,        0,  0,  1, 32'h22,  32'h0,        32'h0,  32'h0,        2'b01, 64'h00000000_FFFF8001, 2'b00, 1,  2};
        vecs[3]  = '{"dwst",   1'b0, 2'b11, 1'b0, 32'h20,  64'h11223344_55667788,     32'h0,        32'h0,        0,  0,  2, 32'h20,  32'h55667788, 32'h24, 32'h11223344, 2'b10, 64'h0,                  2'b00, 2,  4};
        vecs[4]  = '{"dwld",   1'b1, 2'b11, 1'b0, 32'h40,  64'h0,                     32'hAAAA0001, 32'hBBBB0002, 0,  1,  2, 32'h40,  32'h0,        32'h44, 32'h0,        2'b10, 64'hBBBB0002_AAAA0001, 2'b00, 3,  5};
        vecs[5]  = '{"wmis",   1'b1, 2'b10, 1'b0, 32'h102, 64'h0,                     32'h0,        32'h0,        0,  0,  0, 32'h0,   32'h0,        32'h0,  32'h0,        2'b00, 64'h0,                  2'b01, 0,  1};
        vecs[6]  = '{"wtmo",   1'b1, 2'b10, 1'b0, 32'h100, 64'h0,                     32'h0,        32'h0,        99, 0,  1, 32'h100, 32'h0,        32'h0,  32'h0,        2'b10, 64'h0,                  2'b10, 16, 17};
        vecs[7]  = '{"bst",    1'b0, 2'b00, 1'b0, 32'h13,  64'hFFEEDDCC_BBAA9988,     32'h0,        32'h0,        0,  0,  1, 32'h13,  32'h00000088, 32'h0,  32'h0,        2'b00, 64'h0,                  2'b00, 1,  2};
        vecs[8]  = '{"hst",    1'b0, 2'b01, 1'b0, 32'h36,  64'h00000000_1234ABCD,     32'h0,        32'h0,        2,  0,  1, 32'h36,  32'h0000ABCD, 32'h0,  32'h0,        2'b01, 64'h0,                  2'b00, 3,  4};
        vecs[9]  = '{"ubyte",  1'b1, 2'b00, 1'b0, 32'h07,  64'h0,                     32'hFFFFFF85, 32'h0,        0,  0,  1, 32'h07,  32'h0,        32'h0,  32'h0,        2'b00, 64'h00000000_00000085, 2'b00, 1,  2};
        vecs[10] = '{"hmis",   1'b1, 2'b01, 1'b1, 32'h33,  64'h0,                     32'h0,        32'h0,        0,  0,  0, 32'h0,   32'h0,        32'h0,  32'h0,        2'b00, 64'h0,                  2'b01, 0,  1};
        vecs[11] = '{"dmis",   1'b0, 2'b11, 1'b0, 32'h44,  64'h12345678_9ABCDEF0,     32'h0,        32'h0,        0,  0,  0, 32'h0,   32'h0,        32'h0,  32'h0,        2'b00, 64'h0,                  2'b01, 0,  1};
        vecs[12] = '{"swld",   1'b1, 2'b10, 1'b1, 32'h80,  64'h0,                     32'h80000000, 32'h0,        0,  0,  1, 32'h80,  32'h0,        32'h0,  32'h0,        2'b10, 64'h00000000_80000000, 2'b00, 1,  2};
        vecs[13] = '{"dwtmo",  1'b1, 2'b11, 1'b0, 32'h48,  64'h0,                     32'h12345678, 32'h0,        0,  99, 2, 32'h48,  32'h0,        32'h4C, 32'h0,        2'b10, 64'h00000000_12345678, 2'b10, 17, 19};
        vecs[14] = '{"wst",    1'b0, 2'b10, 1'b0, 32'h08,  64'h99999999_DEADBEEF,     32'h0,        32'h0,        2,  0,  1, 32'h08,  32'hDEADBEEF, 32'h0,  32'h0,        2'b10, 64'h0,                  2'b00, 3,  4};

        Reset_n = 1'b0; Start = 1'b0; RW = 1'b0; dataSize = 2'b00; SignedLd = 1'b0;
        Addr = 32'd0; WrData = 64'd0; MemMOC = 1'b0; MemDataIn = 32'd0;
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Start while busy and Start in the Done cycle are both ignored.
        issue(1'b1, 2'b10, 1'b0, 32'h200, 64'h0);
        @(negedge Clk);
        chk("busy_mfa", {63'd0, MemMFA}, 64'd1);
        Start = 1'b1; RW = 1'b0; Addr = 32'h300; WrData = 64'h55;
        @(negedge Clk);
        Start = 1'b0;
        chk("busy_addr_kept", {32'd0, MemAddr}, 64'h200);
        chk("busy_rw_kept", {63'd0, MemRW}, 64'd1);
        MemMOC = 1'b1; MemDataIn = 32'hCAFEF00D;
        @(negedge Clk);
        chk("busy_done", {63'd0, Done}, 64'd1);
        MemMOC = 1'b0; MemDataIn = 32'd0;
        Start = 1'b1; RW = 1'b0; Addr = 32'h300;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_in_done_ignored", {62'd0, Busy, MemMFA}, 64'd0);
        chk("busy_rd", RdData, 64'h00000000_CAFEF00D);
        @(negedge Clk);
        chk("still_idle", {62'd0, Busy, MemMFA}, 64'd0);

        // Reset asserted during the GAP of a doubleword load.
        issue(1'b1, 2'b11, 1'b0, 32'h40, 64'h0);
        @(negedge Clk);
        Start = 1'b0;
        chk("rg_req", {63'd0, MemMFA}, 64'd1);
        MemMOC = 1'b1; MemDataIn = 32'hAAAA0001;
        @(negedge Clk);
        MemMOC = 1'b0; MemDataIn = 32'd0;
        chk("rg_gap", {62'd0, MemMFA, Busy}, 64'd1);
        chk("rg_partial_rd", RdData, 64'h00000000_AAAA0001);
        #2 Reset_n = 1'b0;
        #1 chk_all_zero("rg_async");
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            chk("rg_no_done", {62'd0, Done, MemMFA}, 64'd0);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        run_vec('{"post_rst", 1'b1, 2'b10, 1'b0, 32'h60, 64'h0, 32'h13572468, 32'h0, 1, 0, 1,
                  32'h60, 32'h0, 32'h0, 32'h0, 2'b10, 64'h00000000_13572468, 2'b00, 2, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
